// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
// Contents: access size encodings, responder FSM state type, wait counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with byte write enables and registered read
// Ports:
//   clk    in      clock, rising edge
//   en     in      access strobe; read and (byte-masked) write happen on this edge
//   be     in [4]  byte write enables, bit n writes byte lane n
//   addr   in [AW] word index
//   wdata  in [32] write data, already lane-steered
//   rdata  out[32] registered read data (old contents on a write)
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with wait states, lane steering and error checks
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   req_valid/req_ready           request handshake (ready high only when idle)
//   req_we, req_addr, req_wdata   store flag, byte address, right-aligned store data
//   req_size, req_unsigned        00 byte / 01 half / 10 word / 11 illegal; zero-extend loads
//   resp_valid                    one-cycle response pulse
//   resp_rdata, resp_err          load data and error flag, zero outside the pulse
//   busy                          inverse of req_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] cnt;
    logic              we_q, uns_q, err_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;

    logic              accept, req_err, acc_go;
    logic              acc_we;
    logic [AW+1:0]     acc_addr;
    logic [31:0]       acc_wdata, ram_wdata, ram_rdata, shifted, ld_data;
    logic [1:0]        acc_size;
    logic [3:0]        lane_be;

    assign accept = req_valid & req_ready;

    // Upper address bits above the RAM range must be zero (DEPTH_WORDS is a power of two).
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                           req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])          req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (|req_addr[31:AW+2])                          req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                size_q  <= req_size;
                cnt     <= req_err ? '0 : WAIT_W'(WAIT_CYCLES);
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        acc_go   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nx = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nx = ST_RESP;
                        acc_go   = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_W'(1)) begin
                    state_nx = ST_RESP;
                    acc_go   = 1'b1;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // With zero wait states the RAM is accessed on the accept edge, so the live
    // request fields are used; otherwise the latched copy is.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr[AW+1:0];
            acc_wdata = req_wdata;
            acc_size  = req_size;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
        end
    end

    always_comb begin
        lane_be   = 4'b1111;
        ram_wdata = acc_wdata;
        case (acc_size)
            SZ_BYTE: begin
                lane_be   = 4'b0001 << acc_addr[1:0];
                ram_wdata = {4{acc_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // A reset on the commit edge drops the access entirely.
    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (acc_go & ~rst),
        .be   (acc_we ? lane_be : 4'b0000),
        .addr (acc_addr[AW+1:2]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        shifted = ram_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: ld_data = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = ram_rdata;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign busy       = ~req_ready;
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v2 = 1'b0, v0 = 1'b0;
    logic        we = 1'b0, uns = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  size = SZ_WORD;

    logic        rdy2, rv2, er2, busy2;
    logic [31:0] rd2;
    logic        rdy0, rv0, er0, busy0;
    logic [31:0] rd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_unsigned(uns),
        .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2), .busy(busy2)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_unsigned(uns),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .busy(busy0)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [1:0] s, bit u,
                                logic [31:0] r, bit e, int l);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
        v.exp_rd = r; v.exp_err = e; v.exp_lat = l;
        return v;
    endfunction

    // One complete access on the selected instance; also checks the response is a single pulse.
    task automatic do_acc(input bit z, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input bit u,
                          output logic [31:0] rd, output bit er, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!(z ? rdy0 : rdy2) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        we = w; addr = a; wdata = d; size = s; uns = u;
        if (z) v0 = 1'b1; else v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v2 = 1'b0;
        lat = 1;
        while (!(z ? rv0 : rv2) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = z ? rd0 : rd2;
        er = z ? er0 : er2;
        @(negedge clk);
        chk("pulse_end_valid", {31'h0, z ? rv0 : rv2}, 32'h0);
        chk("after_resp_ready", {31'h0, z ? rdy0 : rdy2}, 32'h1);
        chk("after_resp_rdata", z ? rd0 : rd2, 32'h0);
    endtask

    task automatic b2b(input bit z, input int wc);
        int acc, rsp, prev;
        acc = 0; rsp = 0; prev = -1;
        @(negedge clk);
        we = 1'b0; addr = 32'h10; size = SZ_WORD; uns = 1'b0;
        if (z) v0 = 1'b1; else v2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (z ? rdy0 : rdy2) begin
                if (prev >= 0) chk("b2b_gap", i - prev, wc + 2);
                prev = i;
                acc++;
            end
            if (z ? rv0 : rv2) begin
                rsp++;
                chk("b2b_rdata", z ? rd0 : rd2, 32'h80ADBEEF);
            end
            @(negedge clk);
        end
        v0 = 1'b0; v2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (z ? rv0 : rv2) rsp++;
            @(negedge clk);
        end
        chk("b2b_accepts", acc, 20 / (wc + 2));
        chk("b2b_resp_per_accept", rsp, acc);
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat, nresp;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, rdy2}, 32'h1);
        chk("rst_busy", {31'h0, busy2}, 32'h0);
        chk("rst_valid", {31'h0, rv2}, 32'h0);
        chk("rst_rdata", rd2, 32'h0);
        chk("rst_err", {31'h0, er2}, 32'h0);
        rst = 1'b0;
        chk("rst0_ready", {31'h0, rdy0}, 32'h1);

        vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 32'h0, 0, 3));
        vecs.push_back(mk(0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEADBEEF, 0, 3));
        vecs.push_back(mk(1, 32'h13, 32'h00000080, SZ_BYTE, 0, 32'h0, 0, 3));
        vecs.push_back(mk(0, 32'h13, 32'h0, SZ_BYTE, 0, 32'hFFFFFF80, 0, 3));
        vecs.push_back(mk(0, 32'h13, 32'h0, SZ_BYTE, 1, 32'h00000080, 0, 3));
        vecs.push_back(mk(0, 32'h10, 32'h0, SZ_WORD, 1, 32'h80ADBEEF, 0, 3));
        vecs.push_back(mk(1, 32'h20, 32'h55667788, SZ_WORD, 0, 32'h0, 0, 3));
        vecs.push_back(mk(1, 32'h22, 32'hABCD1234, SZ_HALF, 0, 32'h0, 0, 3));
        vecs.push_back(mk(0, 32'h22, 32'h0, SZ_HALF, 0, 32'h00001234, 0, 3));
        vecs.push_back(mk(0, 32'h20, 32'h0, SZ_WORD, 0, 32'h12347788, 0, 3));
        vecs.push_back(mk(1, 32'h20, 32'h00008001, SZ_HALF, 0, 32'h0, 0, 3));
        vecs.push_back(mk(0, 32'h20, 32'h0, SZ_HALF, 0, 32'hFFFF8001, 0, 3));
        vecs.push_back(mk(0, 32'h20, 32'h0, SZ_HALF, 1, 32'h00008001, 0, 3));
        vecs.push_back(mk(0, 32'h21, 32'h0, SZ_BYTE, 0, 32'hFFFFFF80, 0, 3));
        vecs.push_back(mk(1, 32'h00, 32'h11111111, SZ_WORD, 0, 32'h0, 0, 3));
        vecs.push_back(mk(0, 32'h11, 32'h0, SZ_WORD, 0, 32'h0, 1, 1));
        vecs.push_back(mk(0, 32'h21, 32'h0, SZ_HALF, 0, 32'h0, 1, 1));
        vecs.push_back(mk(0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1, 1));
        vecs.push_back(mk(0, DEPTH * 4, 32'h0, SZ_WORD, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 32'h12, 32'hFFFFFFFF, SZ_WORD, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 32'h11, 32'h0000FFFF, SZ_HALF, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, DEPTH * 4, 32'hCAFEF00D, SZ_WORD, 0, 32'h0, 1, 1));
        vecs.push_back(mk(1, 32'h10, 32'h77777777, 2'b11, 0, 32'h0, 1, 1));
        vecs.push_back(mk(0, 32'h00, 32'h0, SZ_WORD, 0, 32'h11111111, 0, 3));
        vecs.push_back(mk(0, 32'h10, 32'h0, SZ_WORD, 0, 32'h80ADBEEF, 0, 3));
        vecs.push_back(mk(0, 32'h20, 32'h0, SZ_WORD, 0, 32'h12348001, 0, 3));

        foreach (vecs[i]) begin
            do_acc(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        b2b(0, 2);

        // Zero-wait-state instance.
        do_acc(1, 1, 32'h10, 32'h80ADBEEF, SZ_WORD, 0, rd, er, lat);
        chk("w0_store_lat", lat, 1);
        do_acc(1, 0, 32'h10, 32'h0, SZ_WORD, 0, rd, er, lat);
        chk("w0_load_rdata", rd, 32'h80ADBEEF);
        chk("w0_load_lat", lat, 1);
        do_acc(1, 0, 32'h12, 32'h0, SZ_WORD, 0, rd, er, lat);
        chk("w0_err", {31'h0, er}, 32'h1);
        chk("w0_err_lat", lat, 1);
        b2b(1, 0);

        // Reset landing on the commit edge of an in-flight store.
        @(negedge clk);
        we = 1'b1; addr = 32'h10; wdata = 32'h99999999; size = SZ_WORD; uns = 1'b0;
        v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        chk("inflight_busy", {31'h0, busy2}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstc_ready", {31'h0, rdy2}, 32'h1);
        chk("rstc_busy", {31'h0, busy2}, 32'h0);
        chk("rstc_valid", {31'h0, rv2}, 32'h0);
        chk("rstc_rdata", rd2, 32'h0);
        chk("rstc_err", {31'h0, er2}, 32'h0);
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            if (rv2) nresp++;
            @(negedge clk);
        end
        chk("rstc_no_resp", nresp, 0);
        do_acc(0, 0, 32'h10, 32'h0, SZ_WORD, 0, rd, er, lat);
        chk("rstc_old_data", rd, 32'h80ADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
